// File: rtl/fsm_level_pkg.sv
// Shared types and helpers for the one-hot level tracker.
// Helpers take a MAX_LEVELS-wide vector; callers zero-extend narrower state.
package fsm_level_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  localparam int MAX_LEVELS = 64;

  function automatic logic is_onehot(input logic [MAX_LEVELS-1:0] v);
    return (v != '0) && ((v & (v - 64'd1)) == '0);
  endfunction

  // OR of set-bit indices; exact only when v is one-hot.
  function automatic logic [5:0] onehot_to_idx(input logic [MAX_LEVELS-1:0] v);
    logic [5:0] idx;
    idx = '0;
    for (int k = 0; k < MAX_LEVELS; k++) begin
      if (v[k]) idx = idx | 6'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fsm_level_dwell_ctr.sv
// Run-length debouncer: emits a one-cycle step_up/step_dn pulse once `in` has
// held one direction for DWELL_CYCLES enabled cycles.
module fsm_level_dwell_ctr
  import fsm_level_pkg::*;
#(
  parameter int DWELL_CYCLES = 1,
  localparam int CW = ($clog2(DWELL_CYCLES + 1) > 1) ? $clog2(DWELL_CYCLES + 1) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic in,
  output logic step_up,
  output logic step_dn
);

  localparam logic [CW-1:0] DWELL_C = CW'(DWELL_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] run;
  dir_t          dir_q;
  dir_t          dir_in;
  logic          full;

  assign dir_in = dir_t'(in);

  // cnt_q never exceeds DWELL_CYCLES-1, so run fits in CW bits.
  always_comb begin
    run = CW'(1);
    if (cnt_q != '0 && dir_in == dir_q) run = cnt_q + CW'(1);
  end

  assign full    = en && !clr && (run == DWELL_C);
  assign step_up = full && (dir_in == DIR_UP);
  assign step_dn = full && (dir_in == DIR_DOWN);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      dir_q <= DIR_DOWN;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (run == DWELL_C) ? '0 : run;
      dir_q <= dir_in;
    end
  end

endmodule

// File: rtl/fsm_onehot_level.sv
// Saturating N-level tracker with one-hot state, debounced steps and recovery
// from corrupted state. Optional sticky error flag: FSM_LEVEL_STICKY_ERR_EN.
module fsm_onehot_level
  import fsm_level_pkg::*;
#(
  parameter int NUM_LEVELS   = 3,
  parameter int DWELL_CYCLES = 1,
  localparam int LW = ($clog2(NUM_LEVELS) > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  in,
  output logic [NUM_LEVELS-1:0] state_onehot,
  output logic [LW-1:0]         level,
  output logic                  at_bottom,
  output logic                  at_top,
  output logic                  err
`ifdef FSM_LEVEL_STICKY_ERR_EN
  ,
  input  logic                  err_clr,
  output logic                  err_sticky
`endif
);

  logic [NUM_LEVELS-1:0] state_q;
  logic [MAX_LEVELS-1:0] state_ext;
  logic [5:0]            idx;
  logic                  step_up;
  logic                  step_dn;

  always_comb begin
    state_ext = '0;
    state_ext[NUM_LEVELS-1:0] = state_q;
  end

  assign err          = !is_onehot(state_ext);
  assign idx          = onehot_to_idx(state_ext);
  assign state_onehot = state_q;
  assign level        = err ? '0 : LW'(idx);
  assign at_bottom    = !err && state_q[0];
  assign at_top       = !err && state_q[NUM_LEVELS-1];

  fsm_level_dwell_ctr #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_ctr (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .clr    (err),
    .in     (in),
    .step_up(step_up),
    .step_dn(step_dn)
  );

  // A step request at either end is absorbed; the counter has already cleared.
  always_ff @(posedge clk) begin
    if (reset || err) begin
      state_q <= NUM_LEVELS'(1);
    end else if (step_up && !state_q[NUM_LEVELS-1]) begin
      state_q <= state_q << 1;
    end else if (step_dn && !state_q[0]) begin
      state_q <= state_q >> 1;
    end
  end

`ifdef FSM_LEVEL_STICKY_ERR_EN
  always_ff @(posedge clk) begin
    if (reset)        err_sticky <= 1'b0;
    else if (err)     err_sticky <= 1'b1;
    else if (err_clr) err_sticky <= 1'b0;
  end
`endif

endmodule

// File: doc/fsm_onehot_level.md
Name: fsm_onehot_level

Overview:
Parametrised saturating level-tracking state machine with a one-hot state register. Each enabled cycle, the serial input `in` moves the level up (in=1) or down (in=0) by one, saturating at the top and bottom levels. A step is taken only after the input has held the same direction for DWELL_CYCLES consecutive enabled cycles. The block also detects corrupted (non-one-hot) state and recovers from it. It is the generalised N-level, debounced successor of the team's 3-state up/down tracker and drives per-level Moore indications to downstream control.

Parameters:
- NUM_LEVELS, 3: number of levels (states); legal range 2 or more.
- DWELL_CYCLES, 1: consecutive same-direction enabled cycles required per step; legal range 1 or more. A value of 1 reproduces the legacy one-step-per-cycle behaviour.
- Derived (localparam) LW = max(1, $clog2(NUM_LEVELS)).
- Derived (localparam) CW = max(1, $clog2(DWELL_CYCLES+1)).

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  sample enable; when 0, all state holds.
- in  input  1  direction: 1 = up, 0 = down.
- state_onehot  output  NUM_LEVELS  raw state register; bit k set means level k.
- level  output  LW  binary index of the current level.
- at_bottom  output  1  level == 0.
- at_top  output  1  level == NUM_LEVELS-1.
- err  output  1  state register is not exactly one-hot.
- err_sticky  output  1  present only with FSM_LEVEL_STICKY_ERR_EN.
- err_clr  input  1  present only with FSM_LEVEL_STICKY_ERR_EN.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset has priority over everything else:
  - state_q = bit 0 set (level 0).
  - run counter cnt_q = 0.
  - dir_q = 0.
  - After reset, outputs are: level=0, at_bottom=1, at_top=0, err=0.
- Enabled cycle (en=1, state legal):
  - run = (cnt_q != 0 && in == dir_q) ? cnt_q+1 : 1.
  - If run == DWELL_CYCLES and the move is not saturated: step one level in the direction of `in`, and cnt_q <= 0.
  - If run == DWELL_CYCLES and the move is saturated (in=1 at top, or in=0 at bottom): no step, and cnt_q <= 0.
  - Otherwise cnt_q <= run.
  - dir_q <= in on every enabled cycle.
- Disabled cycle (en=0): state_q, cnt_q and dir_q all hold. A disabled cycle neither breaks nor extends a run.
- Latency: all outputs are Moore, decoded from state_q. They change on the clock edge that commits the step, one cycle after the qualifying `in` sample.
- Direction change: a reversal of `in` restarts the run at 1. A partial run in the old direction never produces a step.
- Error handling:
  - err = 1 combinationally whenever popcount(state_q) != 1.
  - While err is asserted: state_onehot shows the raw value, level=0, at_top=0, at_bottom=0.
  - On the next edge, state_q is forced to level 0 and cnt_q to 0, regardless of en or in. Recovery therefore takes one cycle.
- NUM_LEVELS=2: at_top and at_bottom are mutually exclusive; level is 1 bit wide.
- Width rules: cnt_q saturates structurally at DWELL_CYCLES, so no wrap-around is possible. `level` is the zero-extended index.

Optional Feature:
- Macro: FSM_LEVEL_STICKY_ERR_EN.
- Defined:
  - Adds the err_sticky output and the err_clr input.
  - err_sticky is set on any cycle with err=1 and holds until err_clr=1 or reset.
  - If err and err_clr are asserted in the same cycle, set wins (err_sticky stays 1).
  - Reset value of err_sticky is 0.
- Undefined: neither port exists, and no sticky logic is synthesised.

Decomposition:
- Package fsm_level_pkg:
  - dir_t enum with DIR_DOWN=1'b0 and DIR_UP=1'b1.
  - Function is_onehot(vector) for the legality check.
  - Function onehot_to_idx for level encoding.
- Natural sub-module: fsm_level_dwell_ctr. It owns cnt_q and dir_q and produces a one-cycle step_up/step_dn pulse. The top-level block owns the one-hot shift register, the saturation check and error recovery.

Test Plan:
1. NUM_LEVELS=3, DWELL=1, reset, then in=1,1,1,0,0,0 with en=1 → level 1,2,2,1,0,0; at_top high only while level=2.
2. NUM_LEVELS=4, DWELL=3, in=1 for 7 cycles → steps after cycles 3 and 6; level=2 after cycle 6 and still 2 after cycle 7.
3. NUM_LEVELS=4, DWELL=3, in=1,1,0,1,1,1 → a single step, on the 6th cycle (the reversal restarted the run); en=0 inserted mid-run → run resumes without reset.
4. NUM_LEVELS=5, DWELL=2, drive to top, then in=1 for 4 cycles → level stays 4 and cnt_q returns to 0 every second cycle; then in=0 for 2 cycles → level 3.
5. Force state_q=5'b00110 → err=1, level=0 that cycle; next cycle state_onehot=5'b00001 and err=0. With FSM_LEVEL_STICKY_ERR_EN: err_sticky=1 until an err_clr pulse.
6. Assert reset mid-run (DWELL=3, cnt_q=2, level=3) → next cycle level=0, cnt_q=0; one in=1 cycle after reset does not step.
